sprite_memory_arbiter: RTL and testbench

Shares the single-port sprite memory between the pixel-read path of the print module and the instruction-write path of the control unit. It also provides a hardware clear sweep. Pixel reads have strict priority and fixed latency. Instruction writes are buffered in a small queue and drained into free cycles. The block sits between the decoded-instruction demux, the print module and `sprite_memory`, all on the 100 MHz domain, and replaces the address multiplexer and its selector.

---
 rtl/sprite_mem_pkg.sv | 14 +
 rtl/write_queue.sv | 49 ++++
 rtl/sprite_memory_arbiter.sv | 142 ++++++++++++++
 tb/tb_sprite_memory_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_mem_pkg.sv
// Shared constants and state encoding for the sprite memory arbiter.
package sprite_mem_pkg;

    localparam int unsigned ADDR_W       = 14;
    localparam int unsigned DATA_W       = 9;
    localparam logic [DATA_W-1:0] CLEAR_VALUE = '0;
    localparam int unsigned READ_LATENCY = 3;

    typedef enum logic {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } arb_state_t;

endpackage

// File: rtl/write_queue.sv
// Synchronous FIFO buffering instruction writes until a free memory slot.
module write_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 23
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = store[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sprite_memory_arbiter.sv
// Arbitrates the single-port sprite memory between pixel reads, queued
// instruction writes and a full-memory clear sweep.
module sprite_memory_arbiter
    import sprite_mem_pkg::*;
#(
    parameter int unsigned       ADDR_W      = sprite_mem_pkg::ADDR_W,
    parameter int unsigned       DATA_W      = sprite_mem_pkg::DATA_W,
    parameter int unsigned       WQ_DEPTH    = 4,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = DATA_W'(sprite_mem_pkg::CLEAR_VALUE)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        rd_req,
    input  logic [ADDR_W-1:0]           rd_addr,
    output logic [DATA_W-1:0]           rd_data,
    output logic                        rd_valid,
    input  logic                        wr_req,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [DATA_W-1:0]           wr_data,
    output logic                        wr_ready,
    output logic                        wr_done,
    output logic                        wr_overflow,
    output logic [$clog2(WQ_DEPTH):0]   queue_level,
    input  logic                        clr_req,
    output logic                        clr_busy,
    output logic                        clr_done,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic                        mem_wren,
    input  logic [DATA_W-1:0]           mem_rdata
);

    localparam int unsigned ENTRY_W = ADDR_W + DATA_W;
    localparam int unsigned PIPE_D  = READ_LATENCY - 1;

    arb_state_t          state;
    logic [ADDR_W-1:0]   clr_cnt;
    logic [PIPE_D-1:0]   rd_pipe;
    logic [ENTRY_W-1:0]  wq_head;
    logic                wq_full;
    logic                wq_empty;
    logic                push;
    logic                grant_rd;
    logic                grant_clr;
    logic                grant_wr;
    logic                clr_last;

    assign wr_ready = !wq_full && (state == RUN);
    assign push     = wr_req && wr_ready;
    assign clr_last = grant_clr && (clr_cnt == '1);

    write_queue #(
        .DEPTH (WQ_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_write_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({wr_addr, wr_data}),
        .pop       (grant_wr),
        .head      (wq_head),
        .level     (queue_level),
        .full      (wq_full),
        .empty     (wq_empty)
    );

    // Slot grant: reads first, then clear sweep, then queue head
    always_comb begin
        grant_rd  = 1'b0;
        grant_clr = 1'b0;
        grant_wr  = 1'b0;
        if (rd_req) begin
            grant_rd = 1'b1;
        end else if (state == CLEAR) begin
            grant_clr = 1'b1;
        end else if (!wq_empty) begin
            grant_wr = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            clr_cnt     <= '0;
            rd_pipe     <= '0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            wr_done     <= 1'b0;
            wr_overflow <= 1'b0;
            clr_busy    <= 1'b0;
            clr_done    <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_wren    <= 1'b0;
        end else begin
            mem_wren <= 1'b0;
            wr_done  <= 1'b0;
            clr_done <= 1'b0;

            // Read return: command, memory capture, then output register
            rd_pipe  <= {rd_pipe[PIPE_D-2:0], grant_rd};
            rd_valid <= rd_pipe[PIPE_D-1];
            if (rd_pipe[PIPE_D-1]) rd_data <= mem_rdata;

            if (wr_req && !wr_ready) wr_overflow <= 1'b1;

            if (grant_rd) begin
                mem_addr <= rd_addr;
            end else if (grant_clr) begin
                mem_addr  <= clr_cnt;
                mem_wdata <= CLEAR_VALUE;
                mem_wren  <= 1'b1;
                clr_cnt   <= clr_cnt + ADDR_W'(1);
            end else if (grant_wr) begin
                mem_addr  <= wq_head[ENTRY_W-1:DATA_W];
                mem_wdata <= wq_head[DATA_W-1:0];
                mem_wren  <= 1'b1;
                wr_done   <= 1'b1;
            end

            case (state)
                RUN: begin
                    if (clr_req) begin
                        state   <= CLEAR;
                        clr_cnt <= '0;
                    end
                end
                CLEAR: begin
                    if (clr_last) begin
                        state    <= RUN;
                        clr_done <= 1'b1;
                    end
                end
                default: state <= RUN;
            endcase

            // Busy stays up through the completion pulse cycle
            clr_busy <= (state == CLEAR) || clr_req;
        end
    end

endmodule

// File: tb/tb_sprite_memory_arbiter.sv
// Directed scoreboard bench for sprite_memory_arbiter with a sync-read memory model.
module tb_sprite_memory_arbiter;

    localparam int unsigned AW    = 14;
    localparam int unsigned DW    = 9;
    localparam int unsigned WORDS = 1 << AW;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [31:0]   due;
    } rd_exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready;
    logic          wr_done;
    logic          wr_overflow;
    logic [2:0]    queue_level;
    logic          clr_req = 1'b0;
    logic          clr_busy;
    logic          clr_done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_wren;
    logic [DW-1:0] mem_rdata = '0;

    logic [DW-1:0] mem_model [WORDS];
    logic          do_fill = 1'b1;

    rd_exp_t          rd_q[$];
    logic [AW+DW-1:0] wr_q[$];

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    int          wr_done_cnt = 0;
    int          clr_done_cnt = 0;
    int          clr_writes = 0;
    int          rd_valid_cnt = 0;
    logic [AW-1:0] clr_exp = '0;

    sprite_memory_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .wr_done     (wr_done),
        .wr_overflow (wr_overflow),
        .queue_level (queue_level),
        .clr_req     (clr_req),
        .clr_busy    (clr_busy),
        .clr_done    (clr_done),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wren    (mem_wren),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        logic [31:0] t;
        if (a == 14'h0010) return 9'h1A5;
        t = 32'(a) * 32'd37 + 32'd5;
        return t[DW-1:0];
    endfunction

    // Single-port memory: captures the command at the edge after it is issued
    always @(posedge clk) begin
        if (do_fill) begin
            for (int a = 0; a < int'(WORDS); a++) mem_model[a] <= pat(AW'(a));
        end else if (mem_wren) begin
            mem_model[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem_model[mem_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_read(input logic [AW-1:0] a);
        rd_req  = 1'b1;
        rd_addr = a;
        rd_q.push_back('{data: pat(a), due: cyc + 3});
    endtask

    task automatic drive_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit accept);
        wr_req  = 1'b1;
        wr_addr = a;
        wr_data = d;
        if (accept) wr_q.push_back({a, d});
    endtask

    // Output monitor: pops expectations as the DUT produces results
    always @(negedge clk) begin
        rd_exp_t          e;
        logic [AW+DW-1:0] w;
        if (reset) begin
            clr_exp = '0;
        end else begin
            if (rd_valid) begin
                rd_valid_cnt++;
                if (rd_q.size() == 0) check("rd_unexpected", 64'(rd_valid), 64'd0);
                else begin
                    e = rd_q.pop_front();
                    check("rd_data", 64'(rd_data), 64'(e.data));
                    check("rd_latency", 64'(cyc), 64'(e.due));
                end
            end
            if (wr_done) begin
                wr_done_cnt++;
                if (wr_q.size() == 0) check("wr_unexpected", 64'(wr_done), 64'd0);
                else begin
                    w = wr_q.pop_front();
                    check("wr_cmd", 64'({mem_wren, mem_addr, mem_wdata}), 64'({1'b1, w}));
                end
            end else if (mem_wren) begin
                check("clr_cmd", 64'({clr_busy, mem_addr, mem_wdata}), 64'({1'b1, clr_exp, 9'h000}));
                clr_exp = clr_exp + AW'(1);
                clr_writes++;
            end
            if (clr_done) begin
                clr_done_cnt++;
                check("clr_done_addr", 64'(mem_addr), 64'h3FFF);
            end
        end
    end

    initial begin
        int n;
        int k;
        int bad;
        int snap;
        int rd_snap;

        // Reset state
        step();
        do_fill = 1'b0;
        step();
        check("reset_outs", 64'({mem_addr, mem_wdata, mem_wren, rd_data, rd_valid, wr_done,
                                 clr_busy, clr_done, wr_overflow, queue_level}), 64'd0);
        check("reset_wr_ready", 64'(wr_ready), 64'd1);
        reset = 1'b0;
        step();

        // Single read at 0x0010
        drive_read(14'h0010);
        step();
        check("t1_cmd", 64'({mem_wren, mem_addr}), 64'({1'b0, 14'h0010}));
        rd_req = 1'b0;
        repeat (4) step();
        check("t1_one_read", 64'(rd_valid_cnt), 64'd1);

        // Four writes under six held reads, fifth write refused
        for (int i = 0; i < 6; i++) begin
            drive_read(AW'(14'h3F10 + i));
            if (i < 5) drive_write(AW'(i + 1), DW'(9'h011 + i), i < 4);
            else wr_req = 1'b0;
            step();
            check("t2_no_wren_on_read", 64'(mem_wren), 64'd0);
            if (i == 3) check("t2_full", 64'({queue_level, wr_ready}), 64'({3'd4, 1'b0}));
            if (i == 4) check("t3_overflow", 64'(wr_overflow), 64'd1);
        end
        rd_req = 1'b0;
        wr_req = 1'b0;
        repeat (8) step();
        check("t2_wr_done_count", 64'(wr_done_cnt), 64'd4);
        check("t2_mem_writes", 64'({mem_model[1], mem_model[2], mem_model[3], mem_model[4]}),
              64'({9'h011, 9'h012, 9'h013, 9'h014}));
        check("t3_dropped_untouched", 64'(mem_model[5]), 64'(pat(14'h0005)));

        // Simultaneous push and pop at level 2
        drive_read(14'h3F20);
        drive_write(14'h0100, 9'h0A1, 1'b1);
        step();
        drive_read(14'h3F21);
        drive_write(14'h0101, 9'h0A2, 1'b1);
        step();
        check("t6_level2", 64'(queue_level), 64'd2);
        rd_req = 1'b0;
        drive_write(14'h0102, 9'h0A3, 1'b1);
        step();
        check("t6_level_hold", 64'({queue_level, wr_done}), 64'({3'd2, 1'b1}));
        wr_req = 1'b0;
        repeat (6) step();
        check("t6_drained", 64'({queue_level, 32'(wr_done_cnt)}), 64'({3'd0, 32'd7}));

        // Clear sweep with interleaved reads and two writes parked in the queue
        drive_read(14'h3F30);
        drive_write(14'h0200, 9'h0B1, 1'b1);
        step();
        drive_read(14'h3F31);
        drive_write(14'h0201, 9'h0B2, 1'b1);
        step();
        drive_read(14'h3F32);
        wr_req  = 1'b0;
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        rd_req  = 1'b0;
        check("t4_enter", 64'({clr_busy, wr_ready, queue_level}), 64'({1'b1, 1'b0, 3'd2}));
        snap = wr_done_cnt;
        n = 0;
        k = 0;
        while (!clr_done && n < 20000) begin
            if (n % 4 == 0 && n < 4000) begin
                drive_read(AW'(14'h3F00 + (k % 256)));
                k++;
            end else begin
                rd_req = 1'b0;
            end
            if (n == 100) drive_write(14'h0300, 9'h0C1, 1'b0);
            else wr_req = 1'b0;
            step();
            n++;
            if (n == 50) check("t4_queue_frozen", 64'({wr_ready, queue_level}), 64'({1'b0, 3'd2}));
        end
        rd_req = 1'b0;
        wr_req = 1'b0;
        check("t4_clr_done", 64'({clr_done, clr_busy}), 64'({1'b1, 1'b1}));
        check("t4_no_drain_during", 64'(wr_done_cnt), 64'(snap));
        step();
        check("t4_busy_low", 64'({clr_busy, clr_done}), 64'd0);
        repeat (6) step();
        check("t4_clr_once", 64'({32'(clr_done_cnt), 32'(clr_writes)}), 64'({32'd1, 32'd16384}));
        check("t4_queue_drained", 64'({queue_level, 32'(wr_done_cnt)}), 64'({3'd0, 32'(snap + 2)}));
        check("t3_overflow_sticky", 64'(wr_overflow), 64'd1);
        bad = 0;
        for (int a = 0; a < int'(WORDS); a++) begin
            if (a == 'h200) begin
                if (mem_model[a] !== 9'h0B1) bad++;
            end else if (a == 'h201) begin
                if (mem_model[a] !== 9'h0B2) bad++;
            end else if (mem_model[a] !== 9'h000) bad++;
        end
        check("t4_mem_cleared", 64'(bad), 64'd0);

        // Reset asserted while the sweep issues address 0x2000
        do_fill = 1'b1;
        step();
        do_fill = 1'b0;
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        n = 0;
        while (!(mem_wren && mem_addr == 14'h2000) && n < 20000) begin
            step();
            n++;
        end
        check("t5_reached_2000", 64'({mem_wren, mem_addr}), 64'({1'b1, 14'h2000}));
        reset = 1'b1;
        #1;
        check("t5_async_outs", 64'({mem_addr, mem_wdata, mem_wren, rd_data, rd_valid, wr_done,
                                    clr_busy, clr_done, wr_overflow, queue_level}), 64'd0);
        check("t5_wr_ready", 64'(wr_ready), 64'd1);
        step();
        step();
        reset = 1'b0;
        step();
        bad = 0;
        for (int a = 0; a < int'(WORDS); a++) begin
            if (a < 'h2000) begin
                if (mem_model[a] !== 9'h000) bad++;
            end else if (mem_model[a] !== pat(AW'(a))) bad++;
        end
        check("t5_partial_clear", 64'(bad), 64'd0);
        rd_snap = rd_valid_cnt;
        drive_read(14'h3000);
        step();
        rd_req = 1'b0;
        repeat (4) step();
        check("t5_read_after_reset", 64'(rd_valid_cnt), 64'(rd_snap + 1));
        check("t5_idle", 64'({clr_busy, queue_level, wr_overflow}), 64'd0);

        check("sb_empty", 64'(rd_q.size() + wr_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
